// File: rtl/axil_sig_dump.sv
// axil_sig_dump: counts clock cycles until the CPU halts (or a watchdog
// expires), then reads the word-aligned signature region [sig_begin, sig_end)
// over an AXI-Lite read master, one read at a time, and emits every word on a
// valid/ready stream with sig_last on the final word. DONE is terminal until
// the next reset.
module axil_sig_dump #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  halt,
    input  logic [ADDR_WIDTH-1:0] sig_begin,
    input  logic [ADDR_WIDTH-1:0] sig_end,
    input  logic [CNT_WIDTH-1:0]  timeout_cycles,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready,
    output logic [DATA_WIDTH-1:0] sig_data,
    output logic                  sig_valid,
    input  logic                  sig_ready,
    output logic                  sig_last,
    output logic                  busy,
    output logic                  done,
    output logic                  timed_out,
    output logic                  rd_err,
    output logic [CNT_WIDTH-1:0]  cycle_count
);

    typedef enum logic [2:0] {
        ST_RUN  = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_OUT  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Address increment between consecutive signature words.
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(STRB_WIDTH);

    // Clears the byte-offset bits so reads always start on a word boundary.
    function automatic logic [ADDR_WIDTH-1:0] align_word(input logic [ADDR_WIDTH-1:0] addr);
        return addr & ~(STEP - ADDR_WIDTH'(1));
    endfunction

    state_e                  state_q;
    logic [CNT_WIDTH-1:0]    cycle_count_q;
    logic [ADDR_WIDTH-1:0]   ptr_q;
    logic [ADDR_WIDTH-1:0]   end_q;
    logic [ADDR_WIDTH-1:0]   araddr_q;
    logic                    arvalid_q;
    logic                    rready_q;
    logic [DATA_WIDTH-1:0]   sig_data_q;
    logic                    sig_valid_q;
    logic                    sig_last_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    timed_out_q;
    logic                    rd_err_q;

    logic [CNT_WIDTH-1:0]    cycle_count_d;
    logic [ADDR_WIDTH-1:0]   begin_ptr_d;
    logic [ADDR_WIDTH:0]     ptr_sum_s;
    logic [ADDR_WIDTH-1:0]   ptr_d;
    logic                    last_word_s;
    logic                    timeout_hit_s;

    // Saturating cycle counter step.
    assign cycle_count_d = (cycle_count_q == {CNT_WIDTH{1'b1}}) ? cycle_count_q
                                                                 : cycle_count_q + CNT_WIDTH'(1);
    assign begin_ptr_d   = align_word(sig_begin);
    // One extra bit catches the pointer wrapping past all-ones; a wrap counts as reaching the end.
    assign ptr_sum_s     = {1'b0, ptr_q} + {1'b0, STEP};
    assign ptr_d         = ptr_sum_s[ADDR_WIDTH-1:0];
    assign last_word_s   = ptr_sum_s[ADDR_WIDTH] | (ptr_d >= end_q);
    assign timeout_hit_s = (timeout_cycles != {CNT_WIDTH{1'b0}}) &&
                           (cycle_count_q == timeout_cycles - CNT_WIDTH'(1));

    // Dump sequencer: run/count, then one AR -> R -> OUT round trip per word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= ST_RUN;
            cycle_count_q <= {CNT_WIDTH{1'b0}};
            ptr_q         <= {ADDR_WIDTH{1'b0}};
            end_q         <= {ADDR_WIDTH{1'b0}};
            araddr_q      <= {ADDR_WIDTH{1'b0}};
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            sig_data_q    <= {DATA_WIDTH{1'b0}};
            sig_valid_q   <= 1'b0;
            sig_last_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timed_out_q   <= 1'b0;
            rd_err_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    cycle_count_q <= cycle_count_d;
                    if (halt || timeout_hit_s) begin
                        // Halt has priority, so the watchdog flag is only set when halt is absent.
                        if (!halt) begin
                            timed_out_q <= 1'b1;
                        end
                        ptr_q <= begin_ptr_d;
                        end_q <= sig_end;
                        if (begin_ptr_d >= sig_end) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= ST_AR;
                            araddr_q  <= begin_ptr_d;
                            arvalid_q <= 1'b1;
                            busy_q    <= 1'b1;
                        end
                    end
                end
                ST_AR: begin
                    if (m_axil_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_R;
                    end
                end
                ST_R: begin
                    if (m_axil_rvalid) begin
                        rready_q    <= 1'b0;
                        sig_data_q  <= m_axil_rdata;
                        sig_valid_q <= 1'b1;
                        sig_last_q  <= last_word_s;
                        if (m_axil_rresp != 2'b00) begin
                            rd_err_q <= 1'b1;
                        end
                        state_q <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (sig_ready) begin
                        sig_valid_q <= 1'b0;
                        sig_last_q  <= 1'b0;
                        if (sig_last_q) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            ptr_q     <= ptr_d;
                            araddr_q  <= ptr_d;
                            arvalid_q <= 1'b1;
                            state_q   <= ST_AR;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_DONE;
                end
                default: begin
                    // Unreachable encoding: park safely in DONE with the bus idle.
                    arvalid_q   <= 1'b0;
                    rready_q    <= 1'b0;
                    sig_valid_q <= 1'b0;
                    sig_last_q  <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b1;
                    state_q     <= ST_DONE;
                end
            endcase
        end
    end

    assign m_axil_araddr  = araddr_q;
    assign m_axil_arprot  = 3'b000;
    assign m_axil_arvalid = arvalid_q;
    assign m_axil_rready  = rready_q;
    assign sig_data       = sig_data_q;
    assign sig_valid      = sig_valid_q;
    assign sig_last       = sig_last_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign timed_out      = timed_out_q;
    assign rd_err         = rd_err_q;
    assign cycle_count    = cycle_count_q;

endmodule

// File: tb/tb_axil_sig_dump.sv
// Directed bench for axil_sig_dump: behavioural AXI-Lite memory slave and
// stream sink on the falling edge, hand-computed expectations per scenario.
module tb_axil_sig_dump;

    logic        clk = 1'b0;
    logic        rstn;
    logic        halt;
    logic [31:0] sig_begin;
    logic [31:0] sig_end;
    logic [31:0] timeout_cycles;
    logic [31:0] m_axil_araddr;
    logic [2:0]  m_axil_arprot;
    logic        m_axil_arvalid;
    logic        m_axil_arready;
    logic [31:0] m_axil_rdata;
    logic [1:0]  m_axil_rresp;
    logic        m_axil_rvalid;
    logic        m_axil_rready;
    logic [31:0] sig_data;
    logic        sig_valid;
    logic        sig_ready;
    logic        sig_last;
    logic        busy;
    logic        done;
    logic        timed_out;
    logic        rd_err;
    logic [31:0] cycle_count;

    int checks   = 0;
    int failures = 0;

    // Slave / sink / monitor state
    logic        slave_en;
    int          ar_delay, err_idx, ar_cnt, rd_idx;
    logic        r_hold, ar_active, r_pend, sv_active;
    logic [31:0] lat_addr, r_addr, ar_first, sv_first;
    int          ar_pulses, ar_unstable, both_viol, sv_unstable;
    int          stall_word, stall_left;
    int          cyc, first_ar_cyc, first_sv_cyc;
    logic [31:0] rx_data[$];
    logic        rx_last[$];

    always #5 clk = ~clk;

    axil_sig_dump dut (
        .clk            (clk),
        .rstn           (rstn),
        .halt           (halt),
        .sig_begin      (sig_begin),
        .sig_end        (sig_end),
        .timeout_cycles (timeout_cycles),
        .m_axil_araddr  (m_axil_araddr),
        .m_axil_arprot  (m_axil_arprot),
        .m_axil_arvalid (m_axil_arvalid),
        .m_axil_arready (m_axil_arready),
        .m_axil_rdata   (m_axil_rdata),
        .m_axil_rresp   (m_axil_rresp),
        .m_axil_rvalid  (m_axil_rvalid),
        .m_axil_rready  (m_axil_rready),
        .sig_data       (sig_data),
        .sig_valid      (sig_valid),
        .sig_ready      (sig_ready),
        .sig_last       (sig_last),
        .busy           (busy),
        .done           (done),
        .timed_out      (timed_out),
        .rd_err         (rd_err),
        .cycle_count    (cycle_count)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Memory contents: 0x100,0x104,0x108,0x10C hold 1,2,3,4; every word unique.
    function automatic logic [31:0] mem_at(input logic [31:0] a);
        return ((a - 32'h100) >> 2) + 32'd1;
    endfunction

    // Memory slave, stream sink and protocol monitor, all on the falling edge.
    initial begin
        m_axil_arready = 1'b0; m_axil_rvalid = 1'b0; m_axil_rdata = 32'd0; m_axil_rresp = 2'b00;
        sig_ready = 1'b0; cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!slave_en) begin
                // bench drives the slave inputs directly
            end else if (!rstn) begin
                m_axil_arready = 1'b0; m_axil_rvalid = 1'b0; r_pend = 1'b0;
                ar_cnt = 0; ar_active = 1'b0; sv_active = 1'b0; sig_ready = 1'b0;
            end else begin
                if (m_axil_arvalid && m_axil_rready) both_viol++;
                if (m_axil_arready) begin
                    m_axil_arready = 1'b0; r_pend = 1'b1; r_addr = lat_addr; ar_active = 1'b0;
                end else if (m_axil_arvalid) begin
                    if (!ar_active) begin
                        ar_active = 1'b1; ar_first = m_axil_araddr; ar_pulses++;
                        if (first_ar_cyc < 0) first_ar_cyc = cyc;
                    end else if (m_axil_araddr !== ar_first) begin
                        ar_unstable++;
                    end
                    if (ar_cnt >= ar_delay) begin
                        m_axil_arready = 1'b1; lat_addr = m_axil_araddr; ar_cnt = 0;
                    end else begin
                        ar_cnt++;
                    end
                end
                if (m_axil_rvalid) begin
                    if (!m_axil_rready) m_axil_rvalid = 1'b0;
                end else if (r_pend && m_axil_rready && !r_hold) begin
                    m_axil_rvalid = 1'b1;
                    m_axil_rdata  = mem_at(r_addr);
                    m_axil_rresp  = (rd_idx == err_idx) ? 2'b10 : 2'b00;
                    rd_idx++; r_pend = 1'b0;
                end
                if (sig_valid) begin
                    if (!sv_active) begin
                        sv_active = 1'b1; sv_first = sig_data;
                        if (first_sv_cyc < 0) first_sv_cyc = cyc;
                    end else if (sig_data !== sv_first) begin
                        sv_unstable++;
                    end
                    if (stall_left > 0 && rx_data.size() == stall_word) begin
                        sig_ready = 1'b0; stall_left--;
                    end else begin
                        sig_ready = 1'b1; rx_data.push_back(sig_data); rx_last.push_back(sig_last);
                        sv_active = 1'b0;
                    end
                end else begin
                    sig_ready = 1'b0;
                end
            end
        end
    end

    task automatic start(input logic [31:0] b, input logic [31:0] e, input logic [31:0] to,
                         input logic h, input int ard, input int erri, input int stw, input int stn);
        @(negedge clk);
        rstn = 1'b0; slave_en = 1'b1; r_hold = 1'b0;
        halt = h; sig_begin = b; sig_end = e; timeout_cycles = to;
        ar_delay = ard; err_idx = erri; stall_word = stw; stall_left = stn;
        repeat (2) @(negedge clk);
        ar_pulses = 0; ar_unstable = 0; both_viol = 0; sv_unstable = 0; rd_idx = 0;
        first_ar_cyc = -1; first_sv_cyc = -1;
        rx_data.delete(); rx_last.delete();
        rstn = 1'b1;
    endtask

    task automatic wait_done(input string tag, input int max);
        int n = 0;
        while (!done && n < max) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, done, 1'b1);
    endtask

    task automatic check_stream(input string tag, input logic [31:0] base, input int n);
        check_eq({tag, "_count"}, rx_data.size(), n);
        for (int i = 0; i < rx_data.size() && i < n; i++) begin
            check_eq({tag, "_data"}, rx_data[i], mem_at(base + 32'(4 * i)));
            check_eq({tag, "_last"}, rx_last[i], (i == n - 1));
        end
    endtask

    task automatic check_reset_vals(input string p);
        check_eq({p, "_arvalid"}, m_axil_arvalid, 1'b0);
        check_eq({p, "_rready"},  m_axil_rready, 1'b0);
        check_eq({p, "_svalid"},  sig_valid, 1'b0);
        check_eq({p, "_slast"},   sig_last, 1'b0);
        check_eq({p, "_sdata"},   sig_data, 32'd0);
        check_eq({p, "_araddr"},  m_axil_araddr, 32'd0);
        check_eq({p, "_arprot"},  m_axil_arprot, 3'd0);
        check_eq({p, "_busy"},    busy, 1'b0);
        check_eq({p, "_done"},    done, 1'b0);
        check_eq({p, "_tmo"},     timed_out, 1'b0);
        check_eq({p, "_rderr"},   rd_err, 1'b0);
        check_eq({p, "_cc"},      cycle_count, 32'd0);
    endtask

    initial begin
        rstn = 1'b0; slave_en = 1'b1; halt = 1'b0; r_hold = 1'b0;
        sig_begin = 32'd0; sig_end = 32'd0; timeout_cycles = 32'd0;
        ar_delay = 0; err_idx = -1; stall_word = -1; stall_left = 0;
        repeat (2) @(negedge clk);
        check_reset_vals("rst0");

        // Halt at cycle 20, four words 1..4
        start(32'h100, 32'h110, 32'd0, 1'b0, 0, -1, -1, 0);
        repeat (19) @(posedge clk);
        #1;
        check_eq("A_cc19", cycle_count, 32'd19);
        check_eq("A_busy_run", busy, 1'b0);
        halt = 1'b1;
        @(posedge clk);
        #1;
        check_eq("A_busy_ar", busy, 1'b1);
        check_eq("A_arvalid", m_axil_arvalid, 1'b1);
        check_eq("A_araddr0", m_axil_araddr, 32'h100);
        wait_done("A_done", 200);
        check_stream("A", 32'h100, 4);
        check_eq("A_cc", cycle_count, 32'd20);
        check_eq("A_tmo", timed_out, 1'b0);
        check_eq("A_rderr", rd_err, 1'b0);
        check_eq("A_busy_end", busy, 1'b0);
        check_eq("A_latency", first_sv_cyc - first_ar_cyc, 2);
        check_eq("A_both", both_viol, 0);

        // Watchdog at 50 cycles, two words
        start(32'h300, 32'h308, 32'd50, 1'b0, 0, -1, -1, 0);
        repeat (49) @(posedge clk);
        #1;
        check_eq("B_tmo49", timed_out, 1'b0);
        @(posedge clk);
        #1;
        check_eq("B_tmo50", timed_out, 1'b1);
        check_eq("B_cc50", cycle_count, 32'd50);
        wait_done("B_done", 200);
        check_stream("B", 32'h300, 2);
        check_eq("B_cc_frozen", cycle_count, 32'd50);

        // Empty region: done next cycle, no reads, no words
        start(32'h200, 32'h200, 32'd0, 1'b1, 0, -1, -1, 0);
        @(posedge clk);
        #1;
        check_eq("C_done", done, 1'b1);
        check_eq("C_busy", busy, 1'b0);
        repeat (5) @(negedge clk);
        check_eq("C_ar", ar_pulses, 0);
        check_eq("C_words", rx_data.size(), 0);
        check_eq("C_done_hold", done, 1'b1);

        // Halt and timeout coincide: halt wins
        start(32'h400, 32'h400, 32'd5, 1'b0, 0, -1, -1, 0);
        repeat (4) @(posedge clk);
        #1;
        halt = 1'b1;
        @(posedge clk);
        #1;
        check_eq("E_tmo", timed_out, 1'b0);
        check_eq("E_cc", cycle_count, 32'd5);
        check_eq("E_done", done, 1'b1);

        // Backpressure on word 2 and slow arready
        start(32'h500, 32'h50C, 32'd0, 1'b1, 3, -1, 1, 10);
        wait_done("D_done", 300);
        check_stream("D", 32'h500, 3);
        check_eq("D_ar", ar_pulses, 3);
        check_eq("D_ar_stable", ar_unstable, 0);
        check_eq("D_data_stable", sv_unstable, 0);
        check_eq("D_stalled", stall_left, 0);
        check_eq("D_both", both_viol, 0);

        // Error response on first of three words; unaligned begin
        start(32'h602, 32'h60C, 32'd0, 1'b1, 0, 0, -1, 0);
        wait_done("F_done", 200);
        check_stream("F", 32'h600, 3);
        check_eq("F_rderr", rd_err, 1'b1);

        // Pointer wrap past all-ones ends the dump
        start(32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'd0, 1'b1, 0, -1, -1, 0);
        wait_done("H_done", 100);
        check_stream("H", 32'hFFFF_FFF8, 2);

        // Reset while waiting for read data, then a late rvalid
        start(32'h700, 32'h710, 32'd0, 1'b1, 0, -1, -1, 0);
        r_hold = 1'b1;
        for (int i = 0; i < 20 && !m_axil_rready; i++) @(negedge clk);
        check_eq("G_in_R", m_axil_rready, 1'b1);
        #2;
        rstn = 1'b0; slave_en = 1'b0; halt = 1'b0;
        m_axil_arready = 1'b0; m_axil_rvalid = 1'b1;
        m_axil_rdata = 32'hDEAD_BEEF; m_axil_rresp = 2'b10;
        #1;
        check_reset_vals("G_rst");
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("G_cc", cycle_count, 32'd3);
        check_eq("G_busy", busy, 1'b0);
        check_eq("G_done", done, 1'b0);
        check_eq("G_svalid", sig_valid, 1'b0);
        check_eq("G_sdata", sig_data, 32'd0);
        check_eq("G_rready", m_axil_rready, 1'b0);
        check_eq("G_arvalid", m_axil_arvalid, 1'b0);
        check_eq("G_rderr", rd_err, 1'b0);
        m_axil_rvalid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
